// File: rtl/vdu_mem_arbiter.sv
`timescale 1ns/1ps
// Arbiter for the single-port display BRAM: VDU fetches win every cycle, CPU gets idle slots.
// Latency: VDU read data one cycle after its enable; uncontended CPU access acks 4 cycles after the strobe.
// Backpressure: CPU waits in PEND while the VDU reads; o_cpu_busy high until ack; strobes while busy are dropped.
// Optional VDU_ARB_STATS_EN adds stall statistics outputs (o_stall_cycles, o_max_stall).
module vdu_mem_arbiter #(
  parameter logic [15:0] BASE_ADDR = 16'h0200,
  parameter int unsigned DISP_SIZE = 512,
  localparam int AW = $clog2(DISP_SIZE)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_vdu_read_en,
  input  logic [15:0]   i_vdu_read_addr,
  output logic [7:0]    o_vdu_data,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [15:0]   i_cpu_addr,
  input  logic [7:0]    i_cpu_wdata,
  output logic          o_cpu_sel,
  output logic          o_cpu_busy,
  output logic          o_cpu_ack,
  output logic [7:0]    o_cpu_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [7:0]    o_mem_wdata,
  input  logic [7:0]    i_mem_rdata
`ifdef VDU_ARB_STATS_EN
  ,
  output logic [15:0]   o_stall_cycles,
  output logic [7:0]    o_max_stall
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          ack_q;
  logic [7:0]    rdata_q;
  logic [7:0]    cap_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q;
  logic [15:0]   cpu_off;
  logic          accept;
  logic          unused_vdu_hi;

  // Offset is unsigned 16-bit so addresses below the base wrap high and miss.
  assign cpu_off       = i_cpu_addr - BASE_ADDR;
  assign o_cpu_sel     = ({16'd0, cpu_off} < DISP_SIZE);
  assign accept        = i_cpu_req && o_cpu_sel && (state_q == S_IDLE);
  assign o_cpu_busy    = (state_q != S_IDLE);
  assign o_cpu_ack     = ack_q;
  assign o_cpu_rdata   = rdata_q;
  assign o_vdu_data    = i_mem_rdata;
  assign o_mem_wdata   = wdata_q;
  assign unused_vdu_hi = ^i_vdu_read_addr[15:AW];

  // Memory port mux: VDU owns the port whenever it reads, CPU only from PEND.
  always_comb begin
    o_mem_en   = 1'b0;
    o_mem_we   = 1'b0;
    o_mem_addr = addr_q;
    if (i_vdu_read_en) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_vdu_read_addr[AW-1:0];
    end else if (state_q == S_PEND) begin
      o_mem_en   = 1'b1;
      o_mem_we   = we_q;
    end
  end

  // Next-state logic for the single-outstanding CPU access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_PEND;
      S_PEND:  if (!i_vdu_read_en) state_d = S_WAIT;
      S_WAIT:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, ack pulse and CPU read data.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_q == S_DONE);
      if (state_q == S_DONE && !we_q) begin
        rdata_q <= cap_q;
      end
    end
  end

  // Latch the CPU op on accept; capture BRAM output at the end of WAIT, because a
  // VDU fetch during WAIT would overwrite the BRAM output register before DONE.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      we_q    <= i_cpu_we;
      addr_q  <= cpu_off[AW-1:0];
      wdata_q <= i_cpu_wdata;
    end
    if (state_q == S_WAIT) begin
      cap_q <= i_mem_rdata;
    end
  end

`ifdef VDU_ARB_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [7:0]  max_stall_q;
  logic [7:0]  cur_stall_q;
  logic [7:0]  cur_stall_inc;

  assign cur_stall_inc  = (cur_stall_q == 8'hFF) ? 8'hFF : cur_stall_q + 8'd1;
  assign o_stall_cycles = stall_cnt_q;
  assign o_max_stall    = max_stall_q;

  // Saturating totals of PEND cycles lost to the VDU, and the longest single wait.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= 16'h0000;
      max_stall_q <= 8'h00;
      cur_stall_q <= 8'h00;
    end else if (accept) begin
      cur_stall_q <= 8'h00;
    end else if (state_q == S_PEND && i_vdu_read_en) begin
      cur_stall_q <= cur_stall_inc;
      if (stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (cur_stall_inc > max_stall_q) max_stall_q <= cur_stall_inc;
    end
  end
`endif

endmodule

// File: tb/tb_vdu_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for vdu_mem_arbiter with a behavioural BRAM and expected-value queues.
module tb_vdu_mem_arbiter;

  localparam logic [15:0] BASE = 16'h0200;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, vdu_en, cpu_req, cpu_we;
  logic [15:0] vdu_addr, cpu_addr;
  logic [7:0]  vdu_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic        cpu_sel, cpu_busy, cpu_ack, mem_en, mem_we;
  logic [8:0]  mem_addr;
`ifdef VDU_ARB_STATS_EN
  logic [15:0] stall_cycles;
  logic [7:0]  max_stall;
`endif

  vdu_mem_arbiter #(.BASE_ADDR(16'h0200), .DISP_SIZE(512)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_vdu_read_en(vdu_en), .i_vdu_read_addr(vdu_addr), .o_vdu_data(vdu_data),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_sel(cpu_sel), .o_cpu_busy(cpu_busy), .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
`ifdef VDU_ARB_STATS_EN
    , .o_stall_cycles(stall_cycles), .o_max_stall(max_stall)
`endif
  );

  // Behavioural single-port BRAM with registered read data.
  logic [7:0] bram [512];
  logic       bram_init;
  always @(posedge clk) begin
    if (bram_init) begin
      for (int i = 0; i < 512; i++) bram[i] <= 8'(i * 7 + 3);
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
    end
  end

  logic [7:0] ref_mem [512];
  logic [7:0] vdu_q[$];
  logic [7:0] cpu_q[$];
  logic [7:0] last_rd;
  bit         vdu_prev;
  int         checks = 0, errors = 0, n_ack = 0;
  logic       obs_sel, obs_busy, obs_ack, obs_en, obs_we;
  logic [8:0] obs_addr;
  logic [7:0] obs_wdata, obs_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare anything the DUT produces this cycle, advance.
  task automatic run_cycle(input bit ve, input logic [15:0] va, input bit rq, input bit we,
                           input logic [15:0] ca, input logic [7:0] wd);
    logic [7:0] e;
    vdu_en = ve; vdu_addr = va; cpu_req = rq; cpu_we = we; cpu_addr = ca; cpu_wdata = wd;
    if (ve) vdu_q.push_back(ref_mem[va[8:0]]);
    #1;
    if (vdu_prev) begin
      e = vdu_q.pop_front();
      check("vdu_data", {24'd0, vdu_data}, {24'd0, e});
    end
    if (cpu_ack === 1'b1) begin
      n_ack++;
      if (cpu_q.size() == 0) check("unexpected_ack", {31'd0, cpu_ack}, 32'd0);
      else begin
        e = cpu_q.pop_front();
        check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e});
      end
    end
    obs_sel = cpu_sel; obs_busy = cpu_busy; obs_ack = cpu_ack; obs_en = mem_en;
    obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_rdata = cpu_rdata;
    vdu_prev = ve;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    run_cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  // Update the reference memory and queue the rdata expected with the ack.
  task automatic push_cpu(input bit we, input logic [15:0] a, input logic [7:0] wd);
    logic [15:0] off;
    off = a - BASE;
    if (we) ref_mem[off[8:0]] = wd;
    else last_rd = ref_mem[off[8:0]];
    cpu_q.push_back(last_rd);
  endtask

  // One CPU access with vdu_n back-to-back VDU reads right after the strobe.
  task automatic cpu_op(input bit we, input logic [15:0] a, input logic [7:0] wd,
                        input int vdu_n, input int exp_lat, input string tag);
    int issue, ack_at;
    logic [15:0] off;
    issue = -1; ack_at = -1; off = a - BASE;
    push_cpu(we, a, wd);
    run_cycle(1'b0, 16'h0, 1'b1, we, a, wd);
    check({tag, "_sel"}, {31'd0, obs_sel}, 32'd1);
    for (int k = 1; k <= 40 && ack_at < 0; k++) begin
      run_cycle(k <= vdu_n, BASE + 16'(k), 1'b0, 1'b0, 16'h0, 8'h0);
      if (k == 1) check({tag, "_busy"}, {31'd0, obs_busy}, 32'd1);
      if (issue < 0 && obs_en && !(k <= vdu_n)) begin
        issue = k;
        check({tag, "_we"}, {31'd0, obs_we}, {31'd0, we});
        check({tag, "_addr"}, {23'd0, obs_addr}, {23'd0, off[8:0]});
        if (we) check({tag, "_wdata"}, {24'd0, obs_wdata}, {24'd0, wd});
      end
      if (obs_ack) ack_at = k;
    end
    check({tag, "_issue"}, issue, exp_lat - 3);
    check({tag, "_ack_lat"}, ack_at, exp_lat);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i * 7 + 3);
    last_rd = 8'h00; vdu_prev = 1'b0;
    rst_n = 1'b0; bram_init = 1'b1;
    idle();
    bram_init = 1'b0;
    idle();
    // Reset state
    check("rst_busy", {31'd0, obs_busy}, 32'd0);
    check("rst_ack", {31'd0, obs_ack}, 32'd0);
    check("rst_rdata", {24'd0, obs_rdata}, 32'd0);
    check("rst_mem_en", {31'd0, obs_en}, 32'd0);
    run_cycle(1'b1, 16'h0203, 1'b0, 1'b0, 16'h0, 8'h0);
    check("rst_vdu_en", {31'd0, obs_en}, 32'd1);
    check("rst_vdu_we", {31'd0, obs_we}, 32'd0);
    rst_n = 1'b1;
    idle();

    // Uncontended write then read-back
    cpu_op(1'b1, 16'h0210, 8'hA5, 0, 4, "wr_a5");
    idle();
    check("ack_one_cycle", {31'd0, obs_ack}, 32'd0);
    cpu_op(1'b0, 16'h0210, 8'h00, 0, 4, "rd_a5");

    // Ten VDU reads hold the CPU off
    cpu_op(1'b0, 16'h0213, 8'h00, 10, 14, "rd_stall");
    idle();
`ifdef VDU_ARB_STATS_EN
    check("stall_cycles", {16'd0, stall_cycles}, 32'd10);
    check("max_stall", {24'd0, max_stall}, 32'd10);
`endif

    // Window boundaries
    run_cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0200, 8'h0);
    check("sel_base", {31'd0, obs_sel}, 32'd1);
    run_cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h03FF, 8'h0);
    check("sel_top", {31'd0, obs_sel}, 32'd1);
    run_cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h01FF, 8'hEE);
    check("sel_below", {31'd0, obs_sel}, 32'd0);
    run_cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0400, 8'hEE);
    check("sel_above", {31'd0, obs_sel}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle();
      check("oow_busy", {31'd0, obs_busy}, 32'd0);
      check("oow_mem_en", {31'd0, obs_en}, 32'd0);
    end

    // Strobe while busy is dropped; strobe in the ack cycle is taken
    n_ack = 0;
    push_cpu(1'b1, 16'h0220, 8'h11);
    run_cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0220, 8'h11);
    idle();
    run_cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0221, 8'h99);
    check("drop_busy", {31'd0, obs_busy}, 32'd1);
    idle();
    push_cpu(1'b0, 16'h0220, 8'h00);
    run_cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0220, 8'h00);
    check("ackcyc_ack", {31'd0, obs_ack}, 32'd1);
    idle();
    check("ackcyc_busy", {31'd0, obs_busy}, 32'd1);
    for (int k = 0; k < 6; k++) idle();
    check("ack_count", n_ack, 32'd2);
    cpu_op(1'b0, 16'h0221, 8'h00, 0, 4, "rd_dropped");

    // Reset during WAIT of a read
    run_cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0210, 8'h00);
    idle();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    last_rd = 8'h00;
    idle();
    check("mid_rst_busy", {31'd0, obs_busy}, 32'd0);
    check("mid_rst_ack", {31'd0, obs_ack}, 32'd0);
    check("mid_rst_rdata", {24'd0, obs_rdata}, 32'd0);
    n_ack = 0;
    for (int k = 0; k < 5; k++) idle();
    check("mid_rst_no_ack", n_ack, 32'd0);
    cpu_op(1'b0, 16'h0210, 8'h00, 0, 4, "rd_after_rst");

    // Write then immediate VDU read of the same location
    push_cpu(1'b1, 16'h0205, 8'h3C);
    run_cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0205, 8'h3C);
    idle();
    check("wr3c_we", {31'd0, obs_we}, 32'd1);
    check("wr3c_addr", {23'd0, obs_addr}, 32'h005);
    run_cycle(1'b1, 16'h0205, 1'b0, 1'b0, 16'h0, 8'h0);
    idle();
    idle();
    check("wr3c_ack", {31'd0, obs_ack}, 32'd1);
    idle();

    check("cpu_q_empty", cpu_q.size(), 32'd0);
    check("vdu_q_empty", vdu_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
